// File: rtl/module_uart_rx_fifo.sv
// UART receiver (8 data bits, LSB first) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module module_uart_rx_fifo #(
    parameter int unsigned CLK_HZ = 10000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    input  logic                     rd_i,
    input  logic                     clr_err_i,
    output logic [7:0]               data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o,
    output logic                     frame_err_o
);
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned AW           = $clog2(DEPTH);
    localparam int unsigned CW           = AW + 1;
    localparam int unsigned TW           = $clog2(CLKS_PER_BIT + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic            rx_d;
    logic [TW-1:0]   tmr;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            push;
    logic [7:0]      push_data;
    logic            bit_done_c;
    logic            stop_err_c;
`ifdef UART_RX_PARITY_EN
    logic            par_err;
`endif

    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_pop_c;
    logic            do_push_c;
    logic            ovr_c;
    logic [CW-1:0]   count_next;
    logic [7:0]      data_next;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection; idle level is high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign bit_done_c = (tmr == TW'(CLKS_PER_BIT - 1));
`ifdef UART_RX_PARITY_EN
    assign stop_err_c = (state == STOP) && bit_done_c && (!rx_s || par_err);
`else
    assign stop_err_c = (state == STOP) && bit_done_c && !rx_s;
`endif

    // Receive FSM: half-bit alignment in START, then one sample per bit period.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            tmr       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push      <= 1'b0;
            push_data <= '0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            push <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_d && !rx_s) begin
                        state <= START;
                        tmr   <= '0;
                    end
                end
                START: begin
                    if (tmr == TW'(HALF_BIT - 1)) begin
                        tmr     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                DATA: begin
                    if (bit_done_c) begin
                        tmr     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_done_c) begin
                        tmr     <= '0;
                        par_err <= (rx_s != ^shreg);
                        state   <= STOP;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (bit_done_c) begin
                        tmr       <= '0;
                        state     <= IDLE;
                        push      <= !stop_err_c;
                        push_data <= shreg;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A push into a full FIFO only succeeds when a pop frees the head slot in the same cycle.
    assign do_pop_c  = rd_i && (count_o != '0);
    assign do_push_c = push && (!full_o || do_pop_c);
    assign ovr_c     = push && full_o && !rd_i;

    always_comb begin
        count_next = count_o;
        if (do_push_c && !do_pop_c) begin
            count_next = count_o + CW'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_next = count_o - CW'(1);
        end
    end

    // Registered head byte: the next entry on a pop, the incoming byte when it lands in an empty FIFO.
    always_comb begin
        data_next = data_o;
        if (do_pop_c) begin
            if (count_o == CW'(1)) begin
                data_next = push_data;
            end else begin
                data_next = mem[rd_ptr + AW'(1)];
            end
        end else if (do_push_c && (count_o == '0)) begin
            data_next = push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_o     <= '0;
            empty_o     <= 1'b1;
            full_o      <= 1'b0;
            data_o      <= '0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            if (do_push_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_o     <= count_next;
            empty_o     <= (count_next == '0);
            full_o      <= (count_next == CW'(DEPTH));
            data_o      <= data_next;
            overrun_o   <= ovr_c      ? 1'b1 : (clr_err_i ? 1'b0 : overrun_o);
            frame_err_o <= stop_err_c ? 1'b1 : (clr_err_i ? 1'b0 : frame_err_o);
        end
    end

endmodule
